muldiv_sequencer: RTL

//  Iterative multiply/divide unit beside the EX-stage ALU; owns the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_datapath.sv | 123 ++++++++++++
 rtl/muldiv_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  // Operation encoding: bit1 = divide, bit0 = signed
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MD_WIDTH = 32;

  // Iteration counter must hold 0..WIDTH-1 with one bit of headroom
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_w(MD_WIDTH);

endpackage

// File: rtl/muldiv_datapath.sv
// Shift/add multiply and restoring divide engine with optional sign fixup (MULDIV_SIGNED_EN).
// Latency: one step per i_step; results are combinational from the accumulator.
// Backpressure: none; the sequencer decides when to load, step and commit.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_dz_now,
  output logic         o_dz,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  // Accumulator: product {hi,lo} for multiply, {remainder, dividend/quotient} for divide
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opnd;
  logic           r_is_div;
  logic           r_dz;

  logic           w_is_div;
  logic           w_dz;
  logic [W-1:0]   w_ld_a;
  logic [W-1:0]   w_ld_b;
  logic [W:0]     w_sum;
  logic [W:0]     w_rem_sh;
  logic           w_ge;
  logic [W-1:0]   w_diff;
  logic [2*W-1:0] w_mul_nxt;
  logic [2*W-1:0] w_div_nxt;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;

  assign w_is_div = (i_op == OP_DIVU) || (i_op == OP_DIV);
  assign w_dz     = w_is_div && (i_b == '0);
  assign o_dz_now = w_dz;
  assign o_dz     = r_dz;

`ifdef MULDIV_SIGNED_EN
  logic w_sgn;
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;
  assign w_sgn   = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg = w_sgn && i_a[W-1];
  assign w_b_neg = w_sgn && i_b[W-1];
  // Iterate on magnitudes; signs are re-applied when the result is read
  assign w_ld_a  = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_ld_b  = w_b_neg ? (~i_b + 1'b1) : i_b;
`else
  assign w_ld_a  = i_a;
  assign w_ld_b  = i_b;
`endif

  // Multiply step: add multiplicand to upper half when LSB set, then shift right
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
  assign w_mul_nxt = {w_sum, r_acc[W-1:1]};

  // Divide step: shift next dividend bit into remainder, subtract divisor if it fits.
  // The remainder stays below the divisor, so the kept value always fits in W bits.
  assign w_rem_sh  = r_acc[2*W-1:W-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff    = w_rem_sh[W-1:0] - r_opnd;
  assign w_div_nxt = {(w_ge ? w_diff : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};

  // Operand load on an accepted request, then one iteration per step
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else if (i_load) begin
      r_is_div <= w_is_div;
      r_dz     <= w_dz;
      if (w_dz) begin
        // Divide-by-zero result preloaded: hi = raw dividend, lo = all ones
        r_acc  <= {i_a, {W{1'b1}}};
        r_opnd <= '0;
      end else if (w_is_div) begin
        r_acc  <= {{W{1'b0}}, w_ld_a};
        r_opnd <= w_ld_b;
      end else begin
        r_acc  <= {{W{1'b0}}, w_ld_b};
        r_opnd <= w_ld_a;
      end
`ifdef MULDIV_SIGNED_EN
      r_neg_q  <= !w_dz && (w_a_neg ^ w_b_neg);
      r_neg_r  <= !w_dz && w_a_neg;
`endif
    end else if (i_step) begin
      r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Product/quotient negated when signs differ; remainder follows the dividend
  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
`else
  assign w_prod = r_acc;
  assign w_quo  = r_acc[W-1:0];
  assign w_rem  = r_acc[2*W-1:W];
`endif

  assign o_hi = r_is_div ? w_rem : w_prod[2*W-1:W];
  assign o_lo = r_is_div ? w_quo : w_prod[W-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; signed ops built only with MULDIV_SIGNED_EN.
// Latency: start accepted at edge N -> done pulse and new HI/LO after edge N+WIDTH+1 (N+1 on divide by zero).
// Backpressure: busy/stall_hilo high in RUN and DONE; start ignored while busy, cancel aborts without commit.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_hilo,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH == MD_WIDTH) ? CNT_W : cnt_w(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_step;
  logic             w_dz_now;
  logic             w_dz;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  // A flush in the same cycle as a request wins over the request
  assign w_accept = (r_state == IDLE) && start && !cancel;
  assign w_step   = (r_state == RUN) && !cancel;

  muldiv_datapath #(
    .W (WIDTH)
  ) u_dp (
    .clk      (CLK),
    .i_rst    (RST),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_op     (op),
    .i_a      (src_a),
    .i_b      (src_b),
    .o_dz_now (w_dz_now),
    .o_dz     (w_dz),
    .o_hi     (w_res_hi),
    .o_lo     (w_res_lo)
  );

  // Sequencer FSM: iteration count, cancel handling and the HI/LO commit
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_div_zero <= 1'b0;
            r_state    <= w_dz_now ? DONE : RUN;
          end
        end
        RUN: begin
          if (cancel) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // Commit at the end of DONE so a flush here still leaves HI/LO untouched
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!cancel) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
            if (w_dz) r_div_zero <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign stall_hilo = r_busy;
  assign done       = r_done;
  assign div_zero   = r_div_zero;
  assign hi         = r_hi;
  assign lo         = r_lo;

endmodule
